// File: rtl/mtm_pkg.sv
// -----------------------------------------------------------------------------
// mtm_pkg
// Shared definitions for the matrix-transpose unit (mtm_unit):
//   - default element width and matrix dimension
//   - rotation direction and readout state encodings
//   - total_width(): width of one packed row (elements * lanes)
// -----------------------------------------------------------------------------
package mtm_pkg;

    localparam int MTM_DATA_WIDTH = 8;
    localparam int MTM_NUM_PE     = 4;

    typedef enum logic {
        ROT_LEFT  = 1'b0,
        ROT_RIGHT = 1'b1
    } rot_dir_e;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_DRAIN = 1'b1
    } rd_state_e;

    function automatic int total_width(input int data_width, input int num_pe);
        return data_width * num_pe;
    endfunction

endpackage

// File: rtl/mtm_rotator.sv
// -----------------------------------------------------------------------------
// mtm_rotator
// Combinational barrel rotator over a WIDTH-bit vector.
//   DIR = ROT_LEFT  : bit n moves to bit (n + amount) mod WIDTH
//   DIR = ROT_RIGHT : bit n moves to bit (n - amount) mod WIDTH
// Ports:
//   data    in   WIDTH            vector to rotate
//   amount  in   $clog2(WIDTH)    rotation distance in bits
//   rotated out  WIDTH            rotated vector
// -----------------------------------------------------------------------------
module mtm_rotator
    import mtm_pkg::*;
#(
    parameter int       WIDTH = 32,
    parameter rot_dir_e DIR   = ROT_LEFT
) (
    input  logic [WIDTH-1:0]         data,
    input  logic [$clog2(WIDTH)-1:0] amount,
    output logic [WIDTH-1:0]         rotated
);

    // A shift by WIDTH yields zero, so amount == 0 degenerates cleanly to data.
    generate
        if (DIR == ROT_LEFT) begin : g_left
            assign rotated = (data << amount) | (data >> (WIDTH - int'(amount)));
        end else begin : g_right
            assign rotated = (data >> amount) | (data << (WIDTH - int'(amount)));
        end
    endgenerate

endmodule

// File: rtl/mtm_unit.sv
// -----------------------------------------------------------------------------
// mtm_unit
// Streaming NUM_PE x NUM_PE matrix transpose. Rows enter one per accepted
// cycle; once a full matrix has been written, its columns stream out as rows
// on the following NUM_PE cycles. Two storage buffers alternate so a new
// matrix can be written while the previous one drains.
//
// Skewed storage: row i is rotated left by i lanes before being written, so
// every bank holds exactly one element of each row and each column. Readout
// of column j reads bank b at address (b-j) mod NUM_PE and undoes the skew
// with a right rotation by j lanes. NUM_PE must be a power of two (2..16) so
// the lane/address arithmetic wraps naturally.
//
// Ports:
//   clk         in   1                      rising-edge clock
//   rst         in   1                      asynchronous active-low reset
//   val         in   1                      input_row carries a valid row
//   input_row   in   [0:NUM_PE-1] x DW      lane k = column k of the row
//   out_val     out  1                      output_row carries a column
//   output_row  out  [0:NUM_PE-1] x DW      lane i = element of source row i
// -----------------------------------------------------------------------------
module mtm_unit
    import mtm_pkg::*;
#(
    parameter int DATA_WIDTH = MTM_DATA_WIDTH,
    parameter int NUM_PE     = MTM_NUM_PE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  val,
    input  logic [DATA_WIDTH-1:0] input_row  [0:NUM_PE-1],
    output logic                  out_val,
    output logic [DATA_WIDTH-1:0] output_row [0:NUM_PE-1]
);

    localparam int TOTAL_WIDTH = total_width(DATA_WIDTH, NUM_PE);
    localparam int AMT_W       = $clog2(TOTAL_WIDTH);
    localparam int IDX_W       = $clog2(NUM_PE);

    logic [TOTAL_WIDTH-1:0] in_shift_input;
    logic [TOTAL_WIDTH-1:0] in_shift_output;
    logic [TOTAL_WIDTH-1:0] out_shift_input;
    logic [TOTAL_WIDTH-1:0] out_shift_output;
    logic [AMT_W-1:0]       in_shift_amt;
    logic [AMT_W-1:0]       out_shift_amt;

    // Control state
    logic [IDX_W-1:0] row_idx;
    logic             wr_sel;
    rd_state_e        rd_state;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_sel;

    logic row_last;
    logic rd_active;

    // Storage: [buffer][bank][address]; contents are never reset.
    logic [DATA_WIDTH-1:0] mem [0:1][0:NUM_PE-1][0:NUM_PE-1];

    logic [IDX_W-1:0] rd_addr [0:NUM_PE-1];

    // Output stage
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] out_row_p1 [0:NUM_PE-1];

    assign row_last  = (row_idx == IDX_W'(NUM_PE - 1));
    assign rd_active = (rd_state == RD_DRAIN);

    // ---- Input side: pack, skew by row index ----
    genvar k;
    generate
        for (k = 0; k < NUM_PE; k++) begin : g_in_pack
            assign in_shift_input[k*DATA_WIDTH +: DATA_WIDTH] = input_row[k];
        end
    endgenerate

    assign in_shift_amt = AMT_W'(row_idx) * AMT_W'(DATA_WIDTH);

    mtm_rotator #(
        .WIDTH (TOTAL_WIDTH),
        .DIR   (ROT_LEFT)
    ) u_in_rot (
        .data    (in_shift_input),
        .amount  (in_shift_amt),
        .rotated (in_shift_output)
    );

    // ---- Storage write: bank b takes lane b at address row_idx ----
    always_ff @(posedge clk) begin
        if (val) begin
            for (int b = 0; b < NUM_PE; b++) begin
                mem[wr_sel][b][row_idx] <= in_shift_output[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Row counting, buffer flip and readout sequencing. A matrix can complete
    // no sooner than NUM_PE edges after the previous one, i.e. exactly when the
    // previous readout issues its last row, so one queued buffer is enough.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_idx  <= '0;
            wr_sel   <= 1'b0;
            rd_state <= RD_IDLE;
            rd_idx   <= '0;
            rd_sel   <= 1'b0;
        end else begin
            if (val) begin
                row_idx <= row_idx + 1'b1;
                if (row_last) begin
                    wr_sel <= ~wr_sel;
                end
            end

            if (val && row_last) begin
                rd_state <= RD_DRAIN;
                rd_idx   <= '0;
                rd_sel   <= wr_sel;
            end else if (rd_active) begin
                rd_idx <= rd_idx + 1'b1;
                if (rd_idx == IDX_W'(NUM_PE - 1)) begin
                    rd_state <= RD_IDLE;
                end
            end
        end
    end

    // ---- Output side: skewed bank read, de-skew by column index ----
    genvar b;
    generate
        for (b = 0; b < NUM_PE; b++) begin : g_rd
            assign rd_addr[b] = IDX_W'(b) - rd_idx;
            assign out_shift_input[b*DATA_WIDTH +: DATA_WIDTH] = mem[rd_sel][b][rd_addr[b]];
        end
    endgenerate

    assign out_shift_amt = AMT_W'(rd_idx) * AMT_W'(DATA_WIDTH);

    mtm_rotator #(
        .WIDTH (TOTAL_WIDTH),
        .DIR   (ROT_RIGHT)
    ) u_out_rot (
        .data    (out_shift_input),
        .amount  (out_shift_amt),
        .rotated (out_shift_output)
    );

    // ---- p1: registered output, forced to zero when not valid ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1     <= 1'b0;
            out_row_p1 <= '{default: '0};
        end else begin
            vld_p1 <= rd_active;
            for (int i = 0; i < NUM_PE; i++) begin
                out_row_p1[i] <= rd_active ? out_shift_output[i*DATA_WIDTH +: DATA_WIDTH]
                                           : '0;
            end
        end
    end

    assign out_val    = vld_p1;
    assign output_row = out_row_p1;

endmodule

// File: tb/tb_mtm_unit.sv
// -----------------------------------------------------------------------------
// tb_mtm_unit
// Two instances: a 4x8-bit unit for the directed scenarios and an 8x16-bit
// unit for long random back-to-back traffic. A queue-of-rows reference model
// holds accepted rows, transposes each completed matrix and schedules its
// columns for emission one per edge, starting on the edge after completion.
// -----------------------------------------------------------------------------
module tb_mtm_unit;

    localparam int N0 = 4;
    localparam int W0 = 8;
    localparam int N1 = 8;
    localparam int W1 = 16;

    // Generic row container: up to 8 lanes of up to 16 bits, lane k = p[k].
    typedef logic [7:0][15:0] prow_t;

    logic clk = 1'b0;
    logic rst;

    logic          val0;
    logic [W0-1:0] row0  [0:N0-1];
    logic          oval0;
    logic [W0-1:0] orow0 [0:N0-1];

    logic          val1;
    logic [W1-1:0] row1  [0:N1-1];
    logic          oval1;
    logic [W1-1:0] orow1 [0:N1-1];

    mtm_unit #(.DATA_WIDTH(W0), .NUM_PE(N0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .val        (val0),
        .input_row  (row0),
        .out_val    (oval0),
        .output_row (orow0)
    );

    mtm_unit #(.DATA_WIDTH(W1), .NUM_PE(N1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .val        (val1),
        .input_row  (row1),
        .out_val    (oval1),
        .output_row (orow1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state, indexed by instance.
    prow_t acc  [0:1][0:7];
    int    cnt  [0:1];
    prow_t pend [0:1][0:15];
    int    ph   [0:1];
    int    pc   [0:1];

    int ones1 = 0;
    int gaps1 = 0;
    bit seen1 = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            cnt[n] = 0;
            ph[n]  = 0;
            pc[n]  = 0;
        end
    endtask

    // One active edge: emit the oldest scheduled column, then accept the row.
    task automatic model_edge(input int inst, input bit v, input prow_t r, input int n,
                              output bit ev, output prow_t er);
        prow_t t;
        ev = 1'b0;
        er = '0;
        if (pc[inst] > 0) begin
            ev         = 1'b1;
            er         = pend[inst][ph[inst]];
            ph[inst]   = (ph[inst] + 1) % 16;
            pc[inst]   = pc[inst] - 1;
        end
        if (v) begin
            acc[inst][cnt[inst]] = r;
            cnt[inst] = cnt[inst] + 1;
            if (cnt[inst] == n) begin
                for (int j = 0; j < n; j++) begin
                    t = '0;
                    for (int i = 0; i < n; i++) t[i] = acc[inst][i][j];
                    pend[inst][(ph[inst] + pc[inst]) % 16] = t;
                    pc[inst] = pc[inst] + 1;
                end
                cnt[inst] = 0;
            end
        end
    endtask

    function automatic prow_t pk_in0();
        prow_t p = '0;
        for (int k = 0; k < N0; k++) p[k] = 16'(row0[k]);
        return p;
    endfunction

    function automatic prow_t pk_out0();
        prow_t p = '0;
        for (int k = 0; k < N0; k++) p[k] = 16'(orow0[k]);
        return p;
    endfunction

    function automatic prow_t pk_in1();
        prow_t p = '0;
        for (int k = 0; k < N1; k++) p[k] = row1[k];
        return p;
    endfunction

    function automatic prow_t pk_out1();
        prow_t p = '0;
        for (int k = 0; k < N1; k++) p[k] = orow1[k];
        return p;
    endfunction

    task automatic set_row0(input prow_t p);
        for (int k = 0; k < N0; k++) row0[k] = p[k][7:0];
    endtask

    task automatic set_row1(input prow_t p);
        for (int k = 0; k < N1; k++) row1[k] = p[k];
    endtask

    // Row i, lane k = {i, A+k}: 0A 0B 0C 0D, 1A ...
    function automatic prow_t dir_row(input int i);
        prow_t p = '0;
        for (int k = 0; k < N0; k++) p[k] = 16'((i << 4) | (10 + k));
        return p;
    endfunction

    function automatic prow_t rnd_row(input int n, input int w);
        prow_t p = '0;
        for (int k = 0; k < n; k++) p[k] = (w == 8) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        return p;
    endfunction

    task automatic step();
        bit          ev0;
        bit          ev1;
        prow_t       er0;
        prow_t       er1;
        logic [31:0] rot;
        logic [31:0] pin;
        ev0 = 1'b0; ev1 = 1'b0; er0 = '0; er1 = '0;
        @(posedge clk);
        if (rst) begin
            model_edge(0, val0, pk_in0(), N0, ev0, er0);
            model_edge(1, val1, pk_in1(), N1, ev1, er1);
        end
        @(negedge clk);
        chk("out_val0", 128'(oval0), 128'(ev0));
        chk("out_row0", 128'(pk_out0()), 128'(er0));
        chk("out_val1", 128'(oval1), 128'(ev1));
        chk("out_row1", 128'(pk_out1()), 128'(er1));
        // Input skew probes on the small instance: amount i*W, lane k -> k+i.
        rot = '0;
        pin = '0;
        for (int k = 0; k < N0; k++) begin
            rot[((k + cnt[0]) % N0) * W0 +: W0] = row0[k];
            pin[k * W0 +: W0] = row0[k];
        end
        chk("in_amt0", 128'(dut0.in_shift_amt), 128'(cnt[0] * W0));
        chk("in_inp0", 128'(dut0.in_shift_input), 128'(pin));
        chk("in_rot0", 128'(dut0.in_shift_output), 128'(rot));
        chk("in_amt1", 128'(dut1.in_shift_amt), 128'(cnt[1] * W1));
        if (pc[0] > 0) chk("out_amt0", 128'(dut0.out_shift_amt), 128'((N0 - pc[0]) * W0));
        if (pc[1] > 0) chk("out_amt1", 128'(dut1.out_shift_amt), 128'((N1 - pc[1]) * W1));
        // Duty tracking on the large instance.
        if (oval1) begin
            seen1 = 1'b1;
            ones1++;
        end else if (seen1 && ones1 < 100 * N1) begin
            gaps1++;
        end
    endtask

    task automatic feed_dir_matrix();
        for (int i = 0; i < N0; i++) begin
            set_row0(dir_row(i));
            val0 = 1'b1;
            step();
        end
        val0 = 1'b0;
    endtask

    initial begin
        rst  = 1'b0;
        val0 = 1'b0;
        val1 = 1'b0;
        set_row0('0);
        set_row1('0);
        model_reset();

        // Reset held, then released with no traffic.
        repeat (3) step();
        rst = 1'b1;
        repeat (10) step();

        // Single directed matrix.
        feed_dir_matrix();
        repeat (6) step();

        // Directed matrix followed immediately by an all-zero matrix.
        feed_dir_matrix();
        for (int i = 0; i < N0; i++) begin
            set_row0('0);
            val0 = 1'b1;
            step();
        end
        val0 = 1'b0;
        repeat (10) step();

        // val toggling 1,0,1,0 with junk data on idle cycles.
        for (int i = 0; i < 2 * N0; i++) begin
            if (i % 2 == 0) begin
                set_row0(dir_row(i / 2));
                val0 = 1'b1;
            end else begin
                set_row0(rnd_row(N0, W0));
                val0 = 1'b0;
            end
            step();
        end
        val0 = 1'b0;
        repeat (8) step();

        // Partial matrix discarded by reset, then one full matrix.
        for (int i = 0; i < 2; i++) begin
            set_row0(rnd_row(N0, W0));
            val0 = 1'b1;
            step();
        end
        val0 = 1'b0;
        rst  = 1'b0;
        model_reset();
        repeat (2) step();
        rst = 1'b1;
        step();
        feed_dir_matrix();
        repeat (8) step();

        // Random back-to-back matrices on the large instance; random data with
        // random gaps on the small instance at the same time.
        for (int m = 0; m < 100; m++) begin
            for (int i = 0; i < N1; i++) begin
                set_row1(rnd_row(N1, W1));
                val1 = 1'b1;
                set_row0(rnd_row(N0, W0));
                val0 = ($urandom_range(0, 2) != 0);
                step();
            end
        end
        val1 = 1'b0;
        val0 = 1'b0;
        repeat (40) step();

        chk("duty_ones1", 128'(ones1), 128'(100 * N1));
        chk("duty_gaps1", 128'(gaps1), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mtm_unit.md
MTM_UNIT -- requirements
Module: mtm_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the element width in bits.
REQ-002 SHALL have parameter NUM_PE, default 4, the matrix dimension and the lanes per row; it SHALL be a power of two, 2..16.
REQ-003 SHALL define local constant TOTAL_WIDTH = DATA_WIDTH*NUM_PE, the packed row width.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 Port: clk  in  1  sole clock, rising edge.
REQ-006 Port: rst  in  1  asynchronous active-low reset.
REQ-007 Port: val  in  1  input_row holds a valid matrix row this cycle.
REQ-008 Port: input_row  in  unpacked [0:NUM_PE-1] of DATA_WIDTH  row elements; lane k is column k.
REQ-009 Port: out_val  out  1  output_row holds a valid transposed row.
REQ-010 Port: output_row  out  unpacked [0:NUM_PE-1] of DATA_WIDTH  lane i holds element of source row i.
REQ-011 SHALL expose internal nets in_shift_input, in_shift_output, out_shift_input and out_shift_output (TOTAL_WIDTH each) and in_shift_amt and out_shift_amt ($clog2(TOTAL_WIDTH) bits each), so the bench can probe them hierarchically.

Function
REQ-012 Packing: lane k SHALL occupy bits [k*DATA_WIDTH +: DATA_WIDTH] of any packed row.
REQ-013 Input rows SHALL be counted only on edges with val=1. Row index i runs 0..NUM_PE-1 and wraps to 0 after NUM_PE-1, which starts a new matrix.
REQ-014 in_shift_input SHALL be the packed input_row; in_shift_amt SHALL be i*DATA_WIDTH; in_shift_output SHALL be in_shift_input rotated left by in_shift_amt bits, so lane k moves to lane (k+i) mod NUM_PE.
REQ-015 Storage SHALL be NUM_PE banks per buffer, two buffers (ping-pong). On an accepted row, bank b of the write buffer SHALL store lane b of in_shift_output at address i.
REQ-016 When row NUM_PE-1 is accepted, the write buffer SHALL flip and the filled buffer SHALL be queued for readout.
REQ-017 Readout of output row j (0..NUM_PE-1): bank b SHALL be read at address (b-j) mod NUM_PE. out_shift_input SHALL be the packed bank reads. out_shift_amt SHALL be j*DATA_WIDTH. out_shift_output SHALL be out_shift_input rotated right by out_shift_amt.
REQ-018 Result: output row j lane i SHALL equal input element [i][j], i.e. output row j is column j.
REQ-019 Outputs SHALL be registered. If the edge accepting row NUM_PE-1 is edge E, output rows 0..NUM_PE-1 SHALL appear after edges E+1..E+NUM_PE, with out_val=1 for exactly those NUM_PE cycles, contiguous.
REQ-020 There is no output backpressure. Input MAY be continuous, one row per cycle: a new matrix SHALL fill the other buffer while the previous one drains, with no loss and no stall.
REQ-021 Gaps in val SHALL only delay the matrix; the order of accepted rows is preserved.
REQ-022 When out_val=0, output_row SHALL be all zeros.
REQ-023 A partial matrix SHALL never be output.

Reset
REQ-024 While rst=0: out_val=0, output_row all zeros, row counter=0, readout counter=0, readout idle, write buffer select=0.
REQ-025 Storage contents MAY be left unreset. Reset mid-matrix or mid-readout SHALL discard all in-flight data.
REQ-026 Reset release SHALL be safe asynchronously; the first row accepted after release is row 0.

Structure
REQ-027 Package mtm_pkg SHALL hold the default DATA_WIDTH and NUM_PE constants and a function computing TOTAL_WIDTH.
REQ-028 A sub-module mtm_rotator (parameters WIDTH and DIR; inputs data and amount; output rotated data) SHALL be instantiated twice: left rotation for the input side, right rotation for the output side.

Verification
REQ-029 Reset held, then released, no val -> out_val=0 and output_row=0 indefinitely.
REQ-030 Rows 0A0B0C0D, 1A1B1C1D, 2A2B2C2D, 3A3B3C3D (lane0 first) on 4 consecutive edges -> over the next 4 cycles: {0A,1A,2A,3A}, {0B,1B,2B,3B}, {0C,1C,2C,3C}, {0D,1D,2D,3D}; in_shift_amt = 0, 8, 16, 24.
REQ-031 Back-to-back: the above matrix followed immediately by an all-zero matrix -> 8 contiguous out_val cycles: 4 transposed rows, then 4 zero rows.
REQ-032 val toggling 1,0,1,0 while supplying the same 4 rows -> identical transposed output, starting one edge after the 4th accepted row.
REQ-033 Reset asserted after 2 rows, then a full matrix supplied -> only that matrix is output, correctly transposed.
REQ-034 Random data, NUM_PE=8 and DATA_WIDTH=16, 100 consecutive matrices -> every output row matches the reference transpose; out_val duty cycle is 100% after the first fill.
